// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and single-cycle ALU function.
// The BUSY state only exists when ALU_EXEC_MUL_EN is defined.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_MUL = 3'b011;

`ifdef ALU_EXEC_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } alu_state_e;
`endif

  typedef struct packed {
    logic [31:0] result;
    logic        illegal;
  } alu_res_t;

  // Multiply is never handled here; it falls into the illegal branch and
  // the top routes it to the iterative multiplier when that is built.
  function automatic alu_res_t alu_single(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    alu_res_t r;
    r.result  = '0;
    r.illegal = 1'b0;
    case (op)
      ALU_ADD: r.result = a + b;
      ALU_SUB: r.result = a - b;
      ALU_AND: r.result = a & b;
      ALU_OR:  r.result = a | b;
      ALU_SLT: r.result = {31'd0, ($signed(a) < $signed(b))};
      default: begin
        r.result  = '0;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned 32x32 shift-add multiplier returning the low 32 bits.
// One partial-product step per cycle; o_done flags the 32nd step.
module alu_mul_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [31:0] o_product
);

  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic        r_busy;
  logic [31:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The final step's sum is handed out combinationally so the top can
  // register it on the same edge that ends the 32-cycle busy window.
  assign o_done    = r_busy && (r_cnt == 5'd31);
  assign o_product = w_acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[30:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake and registered result.
// Define ALU_EXEC_MUL_EN to add the 32-cycle iterative multiply (code 011).
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);

  alu_state_e  r_state;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_illegal;
  logic        w_in_ready;
  logic        w_accept;
  alu_res_t    w_single;

  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_single   = alu_single(alu_control, src_a, src_b);

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

`ifdef ALU_EXEC_MUL_EN
  logic        w_mul_start;
  logic        w_mul_done;
  logic [31:0] w_mul_product;

  assign w_mul_start = w_accept && (alu_control == ALU_MUL);

  alu_mul_iter u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (src_a),
    .i_b       (src_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
`ifdef ALU_EXEC_MUL_EN
            if (alu_control == ALU_MUL) begin
              r_state <= BUSY;
            end else
`endif
            begin
              r_result  <= w_single.result;
              r_zero    <= (w_single.result == '0);
              r_illegal <= w_single.illegal;
              r_state   <= DONE;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
          end
        end
`ifdef ALU_EXEC_MUL_EN
        BUSY: begin
          if (w_mul_done) begin
            r_result  <= w_mul_product;
            r_zero    <= (w_mul_product == '0);
            r_illegal <= 1'b0;
            r_state   <= DONE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results,
// a negedge monitor compares whenever out_valid is high.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        il;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares every cycle the output is valid, pops on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("result",  result,           sb[0].r);
        chk("zero",    {31'd0, zero},    {31'd0, sb[0].z});
        chk("illegal", {31'd0, illegal}, {31'd0, sb[0].il});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic eil, input bit push);
    int unsigned waited;
    waited = 0;
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    @(negedge clk);
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{er, ez, eil});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd0);
    chk("rst_illegal",   {31'd0, illegal},   32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    idle_cycle();

    // add wrap with one-cycle latency
    issue(3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_latency", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // back-to-back stream
    issue(3'b111, 32'h8000_0000, 32'h0000_0001, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(3'b111, 32'h0000_0001, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b1);
    issue(3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b1);
    issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b1);
    issue(3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    issue(3'b110, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();

    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(3'b110, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(3'b001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1'b1);

    // illegal codes, then recovery
    issue(3'b100, 32'h55, 32'hAA, 32'd0, 1'b1, 1'b1, 1'b1);
    issue(3'b010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
    issue(3'b101, 32'h1, 32'h1, 32'd0, 1'b1, 1'b1, 1'b1);
`ifndef ALU_EXEC_MUL_EN
    issue(3'b011, 32'h3, 32'h4, 32'd0, 1'b1, 1'b1, 1'b1);
`endif
    issue(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();

`ifdef ALU_EXEC_MUL_EN
    // multiply: 32 busy cycles, result on cycle 33
    issue(3'b011, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_busy_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    issue(3'b011, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(3'b010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // reset during multiply: nothing may come out
    issue(3'b011, 32'd9, 32'd9, 32'd81, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_output", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
`endif

    repeat (3) idle_cycle();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
